drp_rmw_sequencer: RTL and testbench
====================================

Name: drp_rmw_sequencer

Overview:
- Master-side DRP sequencer sitting directly upstream of the PLL dynamic-reconfiguration port model.
- Accepts a stream of masked register updates and performs read-modify-write on each over the DRP bus (DADDR/DEN/DWE/DI/DO/DRDY).
- Holds the PLL in reset for the whole sequence, then waits for LOCKED before reporting completion.
- Used by benches and top-level sims to retune CLKOUTn/CLKFBOUT/DIVCLK at runtime.

Parameters:
- DRDY_TIMEOUT, 64, max DCLK cycles waited for DRDY after a DEN cycle; 0 disables the timeout.
- LOCK_TIMEOUT, 100000, max DCLK cycles waited for LOCKED after PLL reset release; 0 disables the timeout.

Ports:
- DCLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  1  update request valid.
- REQ_READY  output  1  sequencer accepts request this cycle.
- REQ_ADDR  input  7  DRP register address.
- REQ_MASK  input  16  1 = keep existing bit, 0 = replace with REQ_DATA bit.
- REQ_DATA  input  16  new bit values.
- REQ_LAST  input  1  final update of the sequence.
- DADDR  output  7  DRP address.
- DEN  output  1  DRP enable, one-cycle strobe.
- DWE  output  1  DRP write enable, valid with DEN.
- DI  output  16  DRP write data.
- DO  input  16  DRP read data, valid when DRDY high.
- DRDY  input  1  DRP access complete.
- PLL_RST  output  1  reset to PLL, high during the sequence.
- LOCKED  input  1  PLL lock status.
- BUSY  output  1  a sequence is in progress.
- DONE  output  1  one-cycle pulse on successful completion.
- ERROR  output  1  sticky; set on timeout, cleared only by RST.

Behaviour:
- Reset values: REQ_READY=0, DADDR=0, DEN=0, DWE=0, DI=0, PLL_RST=0, BUSY=0, DONE=0, ERROR=0, FSM=IDLE, counters=0.
- A reset mid-sequence aborts immediately. The next cycle drives DEN=0 and PLL_RST=0.
- FSM states: IDLE, ACCEPT, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, DONE, FAIL.
- IDLE:
  - REQ_READY=1 while ERROR=0.
  - On REQ_VALID&REQ_READY: latch addr/mask/data/last, set PLL_RST=1 and BUSY=1, go to RD.
- RD: DEN=1, DWE=0, DADDR=latched addr for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - Completion is DRDY=1 in any cycle after the DEN cycle. DRDY in the DEN cycle itself is ignored.
  - On completion, compute DI = (DO & mask) | (data & ~mask) and go to WR.
- WR: DEN=1, DWE=1, DADDR and DI held, one cycle, then WR_WAIT.
- WR_WAIT, on DRDY:
  - If last=0: REQ_READY=1. Wait in ACCEPT (PLL_RST stays 1) for the next request, latch it, go to RD.
  - If last=1: drop PLL_RST, go to LOCK_WAIT.
- ACCEPT has no timeout; the upstream side paces the sequence.
- LOCK_WAIT:
  - LOCKED is ignored for the first 2 cycles after PLL_RST falls (stale lock).
  - After that, LOCKED=1 → DONE.
- DONE: DONE=1 for one cycle, BUSY=0, return to IDLE.
- Timeouts:
  - Each wait counter resets on entry to its wait state.
  - Reaching DRDY_TIMEOUT (RD_WAIT/WR_WAIT) or LOCK_TIMEOUT (LOCK_WAIT) → FAIL.
- FAIL: ERROR=1, PLL_RST=0, DEN=0, BUSY=0. Stays in FAIL with REQ_READY=0 until RST.
- DEN is never high on two consecutive cycles. DEN is never issued while an access is outstanding.
- REQ_READY is high only in IDLE and ACCEPT. At most one request is in flight; there is no buffering.
- Spurious DRDY outside RD_WAIT/WR_WAIT is ignored.

Optional Feature:
- Macro DRP_READBACK_VERIFY_EN.
- Defined: after each WR_WAIT completes, an extra VERIFY read (one-cycle DEN, DWE=0) runs to the same address.
  - If DO differs from the written DI, go to FAIL (ERROR=1). A non-zero DRDY timeout still applies.
  - On match, continue as normal.
  - Adds one DRP read, at least 2 cycles, per update.
- Undefined: no verify read; WR_WAIT proceeds directly.

Test Plan:
- Single update: DO model returns 16'h1234; request ADDR=7'h08, MASK=16'hF000, DATA=16'h0ABC, LAST=1 → read then write at 7'h08 with DI=16'h1ABC; PLL_RST high from accept to write completion; LOCKED raised 5 cycles later → DONE pulse, BUSY low.
- Two-update sequence: 7'h08 then 7'h09 with LAST only on the second → PLL_RST stays high across both, exactly 4 DEN strobes, DWE pattern 0,1,0,1.
- DRDY timeout: DRDY_TIMEOUT=8 and DRDY never asserted → ERROR=1 in cycle 8 of RD_WAIT, PLL_RST=0, REQ_READY=0 until RST.
- Lock timeout: LOCK_TIMEOUT=20 and LOCKED held 0 → ERROR set, no DONE pulse.
- Reset mid-write: RST asserted during WR_WAIT → next cycle all outputs at reset values; a new request then completes normally.
- With DRP_READBACK_VERIFY_EN: model corrupts bit 0 on readback → ERROR=1 after the verify read; with it matching → DONE after 3 DEN strobes.

Source files
------------

// File: rtl/drp_rmw_sequencer.sv
// DRP read-modify-write sequencer: applies masked register updates under PLL reset, then waits for lock.
// Optional readback check of every write is enabled by defining DRP_READBACK_VERIFY_EN.
module drp_rmw_sequencer #(
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 100000
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [6:0]  REQ_ADDR,
  input  logic [15:0] REQ_MASK,
  input  logic [15:0] REQ_DATA,
  input  logic        REQ_LAST,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 4);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_IGNORE = CNT_W'(2);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ACCEPT    = 4'd1;
  localparam logic [3:0] S_RD        = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_WR        = 4'd4;
  localparam logic [3:0] S_WR_WAIT   = 4'd5;
  localparam logic [3:0] S_LOCK_WAIT = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_FAIL      = 4'd8;
`ifdef DRP_READBACK_VERIFY_EN
  localparam logic [3:0] S_VF        = 4'd9;
  localparam logic [3:0] S_VF_WAIT   = 4'd10;
`endif

  logic [3:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      mask_q, mask_n, data_q, data_n, di_n;
  logic             last_q, last_n;
  logic [6:0]       addr_n;
  logic             ready_n, den_n, dwe_n, pll_rst_n, busy_n, done_n, error_n;
  logic             vf_rd_n, vf_any_n, drdy_to, lock_to;

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      DADDR     <= '0;
      DI        <= '0;
      REQ_READY <= 1'b0;
      DEN       <= 1'b0;
      DWE       <= 1'b0;
      PLL_RST   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mask_q    <= mask_n;
      data_q    <= data_n;
      last_q    <= last_n;
      DADDR     <= addr_n;
      DI        <= di_n;
      REQ_READY <= ready_n;
      DEN       <= den_n;
      DWE       <= dwe_n;
      PLL_RST   <= pll_rst_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
      ERROR     <= error_n;
    end
  end

  always_comb begin
    state_n  = state;
    mask_n   = mask_q;
    data_n   = data_q;
    last_n   = last_q;
    addr_n   = DADDR;
    di_n     = DI;
    vf_rd_n  = 1'b0;
    vf_any_n = 1'b0;
    drdy_to  = (DRDY_TIMEOUT != 0) && (cnt == DRDY_LAST);
    lock_to  = (LOCK_TIMEOUT != 0) && (cnt == LOCK_LAST);

    case (state)
      S_IDLE, S_ACCEPT: begin
        if (REQ_VALID && REQ_READY) begin
          addr_n  = REQ_ADDR;
          mask_n  = REQ_MASK;
          data_n  = REQ_DATA;
          last_n  = REQ_LAST;
          state_n = S_RD;
        end
      end
      S_RD: state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        if (DRDY) begin
          di_n    = (DO & mask_q) | (data_q & ~mask_q);
          state_n = S_WR;
        end else if (drdy_to) begin
          state_n = S_FAIL;
        end
      end
      S_WR: state_n = S_WR_WAIT;
      S_WR_WAIT: begin
        if (DRDY) begin
`ifdef DRP_READBACK_VERIFY_EN
          state_n = S_VF;
`else
          state_n = last_q ? S_LOCK_WAIT : S_ACCEPT;
`endif
        end else if (drdy_to) begin
          state_n = S_FAIL;
        end
      end
`ifdef DRP_READBACK_VERIFY_EN
      S_VF: state_n = S_VF_WAIT;
      S_VF_WAIT: begin
        if (DRDY) begin
          if (DO != DI) state_n = S_FAIL;
          else          state_n = last_q ? S_LOCK_WAIT : S_ACCEPT;
        end else if (drdy_to) begin
          state_n = S_FAIL;
        end
      end
`endif
      // Lock seen within two cycles of reset release may be stale.
      S_LOCK_WAIT: begin
        if (LOCKED && (cnt >= LOCK_IGNORE)) state_n = S_DONE;
        else if (lock_to)                   state_n = S_FAIL;
      end
      S_DONE:  state_n = S_IDLE;
      S_FAIL:  state_n = S_FAIL;
      default: state_n = S_IDLE;
    endcase

    // Wait counter restarts on every state change and saturates.
    if (state_n != state) cnt_n = '0;
    else if (cnt == '1)   cnt_n = cnt;
    else                  cnt_n = cnt + CNT_W'(1);

`ifdef DRP_READBACK_VERIFY_EN
    vf_rd_n  = (state_n == S_VF);
    vf_any_n = (state_n == S_VF) || (state_n == S_VF_WAIT);
`endif

    error_n   = ERROR || (state_n == S_FAIL);
    ready_n   = ((state_n == S_IDLE) || (state_n == S_ACCEPT)) && !error_n;
    den_n     = (state_n == S_RD) || (state_n == S_WR) || vf_rd_n;
    dwe_n     = (state_n == S_WR);
    pll_rst_n = (state_n == S_ACCEPT) || (state_n == S_RD) || (state_n == S_RD_WAIT) ||
                (state_n == S_WR) || (state_n == S_WR_WAIT) || vf_any_n;
    busy_n    = pll_rst_n || (state_n == S_LOCK_WAIT);
    done_n    = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_drp_rmw_sequencer.sv
// Directed bench for drp_rmw_sequencer with a behavioural DRP slave and PLL lock model.
module tb_drp_rmw_sequencer;

  logic        DCLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [6:0]  REQ_ADDR = '0;
  logic [15:0] REQ_MASK = '0;
  logic [15:0] REQ_DATA = '0;
  logic        REQ_LAST = 1'b0;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;
  logic        PLL_RST;
  logic        LOCKED = 1'b0;
  logic        BUSY, DONE, ERROR;

  drp_rmw_sequencer #(.DRDY_TIMEOUT(8), .LOCK_TIMEOUT(20)) dut (
    .DCLK(DCLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_MASK(REQ_MASK), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 DCLK = ~DCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Slave/lock model state
  logic [15:0] mem [0:127];
  logic [6:0]  acc_addr [0:15];
  logic        acc_dwe  [0:15];
  logic [15:0] acc_di   [0:15];
  bit   drdy_en = 1'b1, spurious = 1'b0, corrupt = 1'b0, lock_en = 1'b1;
  int   lat = 2, lock_delay = 5;
  bit   pending = 1'b0, p_dwe = 1'b0, last_was_wr = 1'b0, den_prev = 1'b0, rst_prev = 1'b0;
  int   cd = 0, lcnt = 0;
  logic [6:0]  p_addr = '0;
  logic [15:0] p_di = '0;
  int   den_count = 0, done_count = 0, fall_count = 0;
  int   overlap_err = 0, consec_err = 0, norst_err = 0;

  always @(negedge DCLK) begin
    DRDY = 1'b0;
    if (RST) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        cd--;
        if (cd == 0) begin
          pending = 1'b0;
          DRDY = 1'b1;
          if (p_dwe) mem[p_addr] = p_di;
          else begin
            DO = mem[p_addr];
            if (corrupt && last_was_wr) DO[0] = ~DO[0];
          end
          last_was_wr = p_dwe;
        end
      end
      if (DEN) begin
        if (pending) overlap_err++;
        if (den_prev) consec_err++;
        if (!PLL_RST) norst_err++;
        acc_addr[den_count % 16] = DADDR;
        acc_dwe[den_count % 16]  = DWE;
        acc_di[den_count % 16]   = DI;
        den_count++;
        if (drdy_en) begin
          pending = 1'b1; cd = lat; p_addr = DADDR; p_dwe = DWE; p_di = DI;
        end
      end
      if (spurious) DRDY = 1'b1;
    end
    den_prev = DEN;
    if (DONE) done_count++;
    if (rst_prev && !PLL_RST) fall_count++;
    rst_prev = PLL_RST;
    if (PLL_RST) begin
      LOCKED = 1'b0; lcnt = 0;
    end else if (lock_en && !LOCKED) begin
      lcnt++;
      if (lcnt >= lock_delay) LOCKED = 1'b1;
    end
  end

  task automatic step();
    @(negedge DCLK);
    #1;
  endtask

  task automatic send_req(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                          input logic l, output bit ok);
    REQ_ADDR = a; REQ_MASK = m; REQ_DATA = d; REQ_LAST = l; REQ_VALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (REQ_READY) ok = 1'b1;
      step();
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_end(input int max, output bit done_seen, output bit err_seen);
    done_seen = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < max && !done_seen && !err_seen; i++) begin
      step();
      if (DONE) done_seen = 1'b1;
      if (ERROR) err_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [28:0] v;
    RST = 1'b1;
    step(); step();
    v = {REQ_READY, DEN, DWE, PLL_RST, BUSY, DONE, ERROR, DADDR, DI};
    n_cmp++;
    if (v !== 29'd0) begin $display("FAIL reset_values got=%h exp=0", v); n_err++; end
    RST = 1'b0;
    step();
    n_cmp++;
    if (REQ_READY !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", REQ_READY); n_err++; end
  endtask

  task automatic test_single();
    bit ok, dn, er;
    int d0, f0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[8] = 16'h1234;
    d0 = den_count; f0 = fall_count;
    send_req(7'h08, 16'hF000, 16'h0ABC, 1'b1, ok);
    n_cmp++;
    if (!ok || {DEN, DWE, PLL_RST, BUSY, DADDR} !== {1'b1, 1'b0, 1'b1, 1'b1, 7'h08}) begin
      $display("FAIL single_rd_strobe ok=%b got=%b%b%b%b %h exp=1011 08", ok, DEN, DWE, PLL_RST, BUSY, DADDR);
      n_err++;
    end
    wait_end(100, dn, er);
    n_cmp++;
    if (!dn || er || BUSY !== 1'b0) begin $display("FAIL single_done done=%b err=%b busy=%b exp=1 0 0", dn, er, BUSY); n_err++; end
    n_cmp++;
    if (DI !== 16'h1ABC || mem[8] !== 16'h1ABC) begin $display("FAIL single_di got=%h mem=%h exp=1abc", DI, mem[8]); n_err++; end
    n_cmp++;
    if (den_count - d0 != 2 || acc_dwe[d0 % 16] !== 1'b0 || acc_dwe[(d0 + 1) % 16] !== 1'b1 ||
        acc_addr[(d0 + 1) % 16] !== 7'h08 || acc_di[(d0 + 1) % 16] !== 16'h1ABC) begin
      $display("FAIL single_accesses dens=%0d exp=2 (rd,wr @08 di=1abc)", den_count - d0); n_err++;
    end
    n_cmp++;
    if (fall_count - f0 != 1 || norst_err != 0) begin
      $display("FAIL single_pll_rst falls=%0d exp=1 den_without_rst=%0d exp=0", fall_count - f0, norst_err); n_err++;
    end
    step();
    n_cmp++;
    if (DONE !== 1'b0 || REQ_READY !== 1'b1) begin $display("FAIL single_done_pulse done=%b ready=%b exp=0 1", DONE, REQ_READY); n_err++; end
  endtask

  task automatic test_two_updates();
    bit ok, dn, er;
    int d0, f0;
    logic [3:0] pat;
    mem[8] = 16'h1234; mem[9] = 16'h00FF;
    d0 = den_count; f0 = fall_count;
    send_req(7'h08, 16'hF000, 16'h0ABC, 1'b0, ok);
    for (int i = 0; i < 40 && !REQ_READY; i++) step();
    step(); step(); step();
    n_cmp++;
    if (REQ_READY !== 1'b1 || PLL_RST !== 1'b1 || BUSY !== 1'b1) begin
      $display("FAIL two_accept_hold ready=%b pll_rst=%b busy=%b exp=1 1 1", REQ_READY, PLL_RST, BUSY); n_err++;
    end
    send_req(7'h09, 16'h00FF, 16'hABCD, 1'b1, ok);
    wait_end(100, dn, er);
    pat = {acc_dwe[d0 % 16], acc_dwe[(d0 + 1) % 16], acc_dwe[(d0 + 2) % 16], acc_dwe[(d0 + 3) % 16]};
    n_cmp++;
    if (!dn || den_count - d0 != 4 || pat !== 4'b0101) begin
      $display("FAIL two_strobes done=%b dens=%0d dwe=%b exp=1 4 0101", dn, den_count - d0, pat); n_err++;
    end
    n_cmp++;
    if (fall_count - f0 != 1 || mem[9] !== 16'hABFF || mem[8] !== 16'h1ABC) begin
      $display("FAIL two_data falls=%0d mem9=%h mem8=%h exp=1 abff 1abc", fall_count - f0, mem[9], mem[8]); n_err++;
    end
    n_cmp++;
    if (consec_err != 0 || overlap_err != 0) begin
      $display("FAIL den_protocol consecutive=%0d overlapped=%0d exp=0 0", consec_err, overlap_err); n_err++;
    end
  endtask

  task automatic test_spurious_drdy();
    int d0;
    d0 = den_count;
    spurious = 1'b1;
    step(); step(); step();
    spurious = 1'b0;
    step();
    n_cmp++;
    if (den_count != d0 || REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
      $display("FAIL spurious_drdy dens=%0d ready=%b busy=%b exp=0 1 0", den_count - d0, REQ_READY, BUSY); n_err++;
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok, dn, er, hit;
    logic [28:0] v;
    int d0;
    lat = 4;
    send_req(7'h10, 16'h0000, 16'h5555, 1'b1, ok);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (DEN && DWE) hit = 1'b1;
      step();
    end
    RST = 1'b1;
    step();
    v = {REQ_READY, DEN, DWE, PLL_RST, BUSY, DONE, ERROR, DADDR, DI};
    n_cmp++;
    if (!hit || v !== 29'd0) begin $display("FAIL reset_mid_write hit=%b got=%h exp=0", hit, v); n_err++; end
    RST = 1'b0;
    step();
    lat = 2;
    d0 = den_count;
    send_req(7'h11, 16'hFF00, 16'h00A5, 1'b1, ok);
    wait_end(100, dn, er);
    n_cmp++;
    if (!dn || er || den_count - d0 != 2 || mem[17] !== 16'h00A5) begin
      $display("FAIL after_reset_update done=%b err=%b dens=%0d mem=%h exp=1 0 2 00a5", dn, er, den_count - d0, mem[17]);
      n_err++;
    end
  endtask

  task automatic test_lock_timeout();
    bit ok, seen_hi, fell, hit;
    int dc0, k;
    lock_en = 1'b0;
    dc0 = done_count;
    send_req(7'h08, 16'hFFFF, 16'h0000, 1'b1, ok);
    seen_hi = 1'b0; fell = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin
      if (PLL_RST) seen_hi = 1'b1;
      else if (seen_hi) fell = 1'b1;
      if (!fell) step();
    end
    hit = 1'b0; k = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(); k++;
      if (ERROR) hit = 1'b1;
    end
    n_cmp++;
    if (!fell || !hit || k != 20) begin $display("FAIL lock_timeout fell=%b err=%b cycles=%0d exp=1 1 20", fell, hit, k); n_err++; end
    n_cmp++;
    if (done_count != dc0 || PLL_RST !== 1'b0 || BUSY !== 1'b0) begin
      $display("FAIL lock_timeout_state dones=%0d pll_rst=%b busy=%b exp=0 0 0", done_count - dc0, PLL_RST, BUSY); n_err++;
    end
    lock_en = 1'b1;
    do_reset();
  endtask

  task automatic test_drdy_timeout();
    bit ok, hit;
    int d0;
    drdy_en = 1'b0;
    send_req(7'h08, 16'h0000, 16'h1111, 1'b1, ok);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (DEN) hit = 1'b1;
      else step();
    end
    d0 = den_count;
    for (int i = 0; i < 8; i++) step();
    n_cmp++;
    if (!hit || ERROR !== 1'b0) begin $display("FAIL drdy_timeout_early den=%b err=%b exp=1 0", hit, ERROR); n_err++; end
    step();
    n_cmp++;
    if ({ERROR, PLL_RST, REQ_READY, BUSY, DEN} !== 5'b10000) begin
      $display("FAIL drdy_timeout got=%b%b%b%b%b exp=10000", ERROR, PLL_RST, REQ_READY, BUSY, DEN); n_err++;
    end
    REQ_VALID = 1'b1;
    for (int i = 0; i < 5; i++) step();
    REQ_VALID = 1'b0;
    n_cmp++;
    if (ERROR !== 1'b1 || REQ_READY !== 1'b0 || den_count != d0) begin
      $display("FAIL error_sticky err=%b ready=%b dens=%0d exp=1 0 0", ERROR, REQ_READY, den_count - d0); n_err++;
    end
    drdy_en = 1'b1;
    do_reset();
    n_cmp++;
    if (ERROR !== 1'b0 || REQ_READY !== 1'b1) begin $display("FAIL error_clear err=%b ready=%b exp=0 1", ERROR, REQ_READY); n_err++; end
  endtask

`ifdef DRP_READBACK_VERIFY_EN
  task automatic test_verify();
    bit ok, dn, er;
    int d0, dc0;
    corrupt = 1'b1;
    d0 = den_count; dc0 = done_count;
    send_req(7'h20, 16'h0000, 16'h4242, 1'b1, ok);
    wait_end(100, dn, er);
    n_cmp++;
    if (!er || dn || done_count != dc0 || den_count - d0 != 3 || acc_dwe[(d0 + 2) % 16] !== 1'b0) begin
      $display("FAIL verify_corrupt err=%b done=%b dens=%0d exp=1 0 3", er, dn, den_count - d0); n_err++;
    end
    corrupt = 1'b0;
    do_reset();
    d0 = den_count;
    send_req(7'h21, 16'h00FF, 16'h7700, 1'b1, ok);
    wait_end(100, dn, er);
    n_cmp++;
    if (!dn || er || den_count - d0 != 3) begin
      $display("FAIL verify_match done=%b err=%b dens=%0d exp=1 0 3", dn, er, den_count - d0); n_err++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    test_reset();
    test_single();
    test_two_updates();
    test_spurious_drdy();
    test_reset_mid_write();
    test_lock_timeout();
    test_drdy_timeout();
`ifdef DRP_READBACK_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached exp=finish");
    $fatal(1);
  end

endmodule
